cache_mem_backend: RTL and testbench
====================================

Name: cache_mem_backend

Overview:
- Storage back-end for the four-way set-associative data cache.
- Holds the 16-line cache array: 4 sets x 4 ways, 136-bit lines, one read port and one write port.
- Holds the 512-word main data memory, with one write port and four asynchronous read ports returning four consecutive words for a line fill.
- Contains no hit/replacement logic; the cache controller drives all addresses and enables.

Parameters:
- LINE_W, 136, cache line width: tag[135:129], valid[128], word0[127:96], word1[95:64], word2[63:32], word3[31:0].
- CACHE_DEPTH, 16, number of cache lines; address = {set[1:0], way[1:0]}.
- MEM_WORDS, 512, main-memory depth in 32-bit words (2 KiB byte space).
- INIT_FILE, "", hex file loaded into main memory at elaboration; empty means all zero.

Ports:
- clk  in  1  single clock; all logic on this clock.
- rst  in  1  asynchronous, active-high reset.
- cache_ra  in  4  cache read address (port A).
- cache_re  in  1  cache read enable.
- cache_rd  out  136  registered cache read data.
- cache_wa  in  4  cache write address (port B).
- cache_we  in  1  cache write enable.
- cache_wd  in  136  cache write data.
- mem_wa  in  9  main-memory write word address.
- mem_we  in  1  main-memory write enable.
- mem_wd  in  32  main-memory write data.
- mem_ra  in  9  main-memory base read word address.
- mem_rd0  out  32  word at mem_ra.
- mem_rd1  out  32  word at mem_ra+1.
- mem_rd2  out  32  word at mem_ra+2.
- mem_rd3  out  32  word at mem_ra+3.

Behaviour:
- Reset (asynchronous, rst=1):
  - All 16 cache lines cleared to 0, so every valid bit is 0.
  - cache_rd forced to 0.
  - Main-memory contents are not affected by reset.
  - While rst=1, writes to the cache array and to main memory are ignored.
- Cache read:
  - On posedge clk with cache_re=1, cache_rd <= line[cache_ra]. Latency is 1 cycle.
  - With cache_re=0, cache_rd holds its value.
- Cache write:
  - Committed on the falling edge of clk when cache_we=1: line[cache_wa] <= cache_wd.
  - Inputs are sampled at that negedge.
  - A write at the negedge of cycle N is visible to a read registered at the posedge starting cycle N+1.
- Same-address hazard: a read registered at posedge returns the content as of the preceding negedge (write-before-read across the half cycle). There is no bypass within the same edge.
- Main-memory write:
  - On posedge clk with mem_we=1, mem[mem_wa] <= mem_wd (word granularity; no byte enables).
- Main-memory read:
  - Combinational; mem_rdK = mem[(mem_ra+K) mod MEM_WORDS] for K=0..3.
  - Addresses wrap at 511 -> 0.
  - Read-old-data before a posedge write; new data appears combinationally after that edge.
- Simultaneous main-memory write and read of the same word: the outputs show old data until the clock edge, then new data.
- Out-of-range addresses cannot occur; widths exactly cover the depths.
- No handshake; all operations complete in the stated cycle.

Decomposition:
- Shared package cache_pkg holds:
  - LINE_W, TAG_W=7, the VALID_BIT index and the word field offsets.
  - SET_W=2, WAY_W=2, MEM_AW=9.
  - The line struct typedef {tag, valid, w0, w1, w2, w3}.
- One natural sub-module, cache_line_ram: 16x136 array with async clear, posedge read and negedge write.
- Main memory is inline: a register array plus four adders.

Test Plan:
- Reset: assert rst mid-run after writing line 5 -> cache_rd=0 immediately; after release, reading line 5 returns 0 (valid bit 0).
- Cache write then read: write cache_wa=4'h9, cache_wd={7'h15,1'b1,32'h11111111,32'h22222222,32'h33333333,32'h44444444} at negedge; read cache_ra=9 at next posedge -> cache_rd equals that value after 1 cycle.
- Same-cycle write/read of line 3: read and write both issued in cycle N -> cycle N+1 read returns old data; cycle N+2 read returns new data.
- Main-memory burst: write words 0x20..0x23 with 0xA0..0xA3; set mem_ra=0x20 -> mem_rd0..3 = 0xA0,0xA1,0xA2,0xA3 combinationally.
- Wrap-around: mem[511]=0xDEAD, mem[0]=0xBEEF, mem_ra=511 -> mem_rd0=0xDEAD, mem_rd1=0xBEEF, mem_rd2=mem[1].
- Write-enable low: cache_we=0 and mem_we=0 with changing data -> no stored contents change; cache_re=0 -> cache_rd holds its value.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, field offsets and the line layout for the data-cache storage back-end.
package cache_pkg;
    localparam int LINE_W    = 136;
    localparam int TAG_W     = 7;
    localparam int WORD_W    = 32;
    localparam int VALID_BIT = 128;
    localparam int W0_LSB    = 96;
    localparam int W1_LSB    = 64;
    localparam int W2_LSB    = 32;
    localparam int W3_LSB    = 0;

    localparam int SET_W       = 2;
    localparam int WAY_W       = 2;
    localparam int CACHE_AW    = SET_W + WAY_W;
    localparam int CACHE_DEPTH = 1 << CACHE_AW;

    localparam int MEM_AW    = 9;
    localparam int MEM_WORDS = 1 << MEM_AW;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              valid;
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
    } line_t;

    // Word address of the k-th word of a fill; wraps naturally at MEM_WORDS.
    function automatic logic [MEM_AW-1:0] memOffset(input logic [MEM_AW-1:0] base,
                                                    input logic [1:0] k);
        return base + MEM_AW'(k);
    endfunction
endpackage

// File: rtl/cache_mem_backend_if.sv
// Controller-facing bus of the cache storage back-end; the controller is the master.
interface cache_mem_backend_if;
    import cache_pkg::*;

    logic [CACHE_AW-1:0] cache_ra;
    logic                cache_re;
    logic [LINE_W-1:0]   cache_rd;
    logic [CACHE_AW-1:0] cache_wa;
    logic                cache_we;
    logic [LINE_W-1:0]   cache_wd;
    logic [MEM_AW-1:0]   mem_wa;
    logic                mem_we;
    logic [WORD_W-1:0]   mem_wd;
    logic [MEM_AW-1:0]   mem_ra;
    logic [WORD_W-1:0]   mem_rd0;
    logic [WORD_W-1:0]   mem_rd1;
    logic [WORD_W-1:0]   mem_rd2;
    logic [WORD_W-1:0]   mem_rd3;

    modport master (
        output cache_ra, cache_re, cache_wa, cache_we, cache_wd,
        output mem_wa, mem_we, mem_wd, mem_ra,
        input  cache_rd, mem_rd0, mem_rd1, mem_rd2, mem_rd3
    );

    modport slave (
        input  cache_ra, cache_re, cache_wa, cache_we, cache_wd,
        input  mem_wa, mem_we, mem_wd, mem_ra,
        output cache_rd, mem_rd0, mem_rd1, mem_rd2, mem_rd3
    );
endinterface

// File: rtl/cache_line_ram.sv
// 16-line cache array: async clear, registered posedge read, negedge write.
module cache_line_ram
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [CACHE_AW-1:0] ra,
    input  logic                re,
    output line_t               rd,
    input  logic [CACHE_AW-1:0] wa,
    input  logic                we,
    input  line_t               wd
);
    line_t lines [CACHE_DEPTH];

    // Writing on the falling edge lets a read at the next rising edge see the data
    // without any bypass path.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CACHE_DEPTH; i++) lines[i] <= '0;
        end else if (we) begin
            lines[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rd <= '0;
        else if (re) rd <= lines[ra];
    end
endmodule

// File: rtl/cache_mem_backend.sv
// Storage back-end for the 4-way data cache: line array plus 512-word main memory
// with a four-word combinational fill port.
module cache_mem_backend
    import cache_pkg::*;
(
    input logic                clk,
    input logic                rst,
    cache_mem_backend_if.slave bus
);
    line_t lineRd;

    cache_line_ram u_lines (
        .clk (clk),
        .rst (rst),
        .ra  (bus.cache_ra),
        .re  (bus.cache_re),
        .rd  (lineRd),
        .wa  (bus.cache_wa),
        .we  (bus.cache_we),
        .wd  (line_t'(bus.cache_wd))
    );

    assign bus.cache_rd = lineRd;

    // Main memory is deliberately left out of reset; only the write is held off.
    logic [WORD_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (!rst && bus.mem_we) mem[bus.mem_wa] <= bus.mem_wd;
    end

    assign bus.mem_rd0 = mem[memOffset(bus.mem_ra, 2'd0)];
    assign bus.mem_rd1 = mem[memOffset(bus.mem_ra, 2'd1)];
    assign bus.mem_rd2 = mem[memOffset(bus.mem_ra, 2'd2)];
    assign bus.mem_rd3 = mem[memOffset(bus.mem_ra, 2'd3)];
endmodule

// File: tb/tb_cache_mem_backend.sv
// Self-checking bench for cache_mem_backend: table-driven cache traffic plus
// hand-written main-memory and reset sequences.
module tb_cache_mem_backend;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_backend_if bus();

    cache_mem_backend dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nCmp  = 0;
    int nFail = 0;

    typedef struct {
        string             name;
        logic              re;
        logic [3:0]        ra;
        logic              we;
        logic [3:0]        wa;
        logic [LINE_W-1:0] wd;
        logic [LINE_W-1:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [LINE_W-1:0] sb[$];

    localparam logic [LINE_W-1:0] L9  = {7'h15, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    localparam logic [LINE_W-1:0] L3A = {7'h03, 1'b1, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    localparam logic [LINE_W-1:0] L3B = {7'h7F, 1'b1, 32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3};
    localparam logic [LINE_W-1:0] LF  = {7'h2A, 1'b0, 32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678, 32'h9ABCDEF0};
    localparam logic [LINE_W-1:0] L5  = {7'h05, 1'b1, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    localparam logic [LINE_W-1:0] JNK = {136{1'b1}};

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic re, input logic [3:0] ra,
                                input logic we, input logic [3:0] wa,
                                input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] exp);
        vec_t v;
        v.name = name; v.re = re; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd; v.exp = exp;
        return v;
    endfunction

    // One cycle of cache traffic: drive just after a falling edge, so the read is
    // registered at the coming rising edge and the write commits at the next falling edge.
    task automatic step(input vec_t v);
        @(negedge clk); #1;
        bus.cache_re = v.re; bus.cache_ra = v.ra;
        bus.cache_we = v.we; bus.cache_wa = v.wa; bus.cache_wd = v.wd;
        sb.push_back(v.exp);
        @(posedge clk); #1;
        chk(v.name, bus.cache_rd, sb.pop_front());
    endtask

    task automatic memWrite(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        bus.mem_we = 1'b1; bus.mem_wa = a; bus.mem_wd = d;
        @(posedge clk); #1;
        bus.mem_we = 1'b0;
    endtask

    initial begin
        bus.cache_re = 0; bus.cache_ra = 0; bus.cache_we = 0; bus.cache_wa = 0; bus.cache_wd = '0;
        bus.mem_we = 0; bus.mem_wa = 0; bus.mem_wd = 0; bus.mem_ra = 0;

        #2;
        chk("reset_rd", bus.cache_rd, '0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;

        vecs.push_back(mk("wr9_idle",     0, 4'd0,  1, 4'd9,  L9,  '0));
        vecs.push_back(mk("rd9",          1, 4'd9,  1, 4'd3,  L3A, L9));
        vecs.push_back(mk("rd3_same_old", 1, 4'd3,  1, 4'd3,  L3B, L3A));
        vecs.push_back(mk("rd3_new",      1, 4'd3,  0, 4'd3,  '0,  L3B));
        vecs.push_back(mk("re0_hold",     0, 4'd9,  0, 4'd9,  JNK, L3B));
        vecs.push_back(mk("we0_rd9",      1, 4'd9,  0, 4'd9,  '0,  L9));
        vecs.push_back(mk("rd0_clean",    1, 4'd0,  0, 4'd0,  JNK, '0));
        vecs.push_back(mk("rd15_same",    1, 4'd15, 1, 4'd15, LF,  '0));
        vecs.push_back(mk("rd15_new",     1, 4'd15, 0, 4'd15, '0,  LF));
        vecs.push_back(mk("re0_hold15",   0, 4'd9,  0, 4'd0,  '0,  LF));
        vecs.push_back(mk("wr5",          0, 4'd0,  1, 4'd5,  L5,  LF));
        vecs.push_back(mk("rd5",          1, 4'd5,  0, 4'd0,  '0,  L5));
        foreach (vecs[i]) step(vecs[i]);

        // main memory burst fill
        for (int k = 0; k < 4; k++) memWrite(9'h20 + 9'(k), 32'hA0 + 32'(k));
        bus.mem_ra = 9'h20; #1;
        chk("burst_rd0", 136'(bus.mem_rd0), 136'(32'hA0));
        chk("burst_rd1", 136'(bus.mem_rd1), 136'(32'hA1));
        chk("burst_rd2", 136'(bus.mem_rd2), 136'(32'hA2));
        chk("burst_rd3", 136'(bus.mem_rd3), 136'(32'hA3));

        // write and read of the same word: old data until the edge
        @(negedge clk); #1;
        bus.mem_ra = 9'h21; bus.mem_we = 1'b1; bus.mem_wa = 9'h21; bus.mem_wd = 32'h5555;
        #1;
        chk("rw_old", 136'(bus.mem_rd0), 136'(32'hA1));
        @(posedge clk); #1;
        bus.mem_we = 1'b0;
        chk("rw_new", 136'(bus.mem_rd0), 136'(32'h5555));
        chk("rw_next", 136'(bus.mem_rd1), 136'(32'hA2));

        // wrap-around at the top of memory
        memWrite(9'd511, 32'hDEAD);
        memWrite(9'd0,   32'hBEEF);
        memWrite(9'd1,   32'h1111);
        memWrite(9'd2,   32'h2222);
        bus.mem_ra = 9'd511; #1;
        chk("wrap_rd0", 136'(bus.mem_rd0), 136'(32'hDEAD));
        chk("wrap_rd1", 136'(bus.mem_rd1), 136'(32'hBEEF));
        chk("wrap_rd2", 136'(bus.mem_rd2), 136'(32'h1111));
        chk("wrap_rd3", 136'(bus.mem_rd3), 136'(32'h2222));

        // write enable low: data changes must not land
        @(negedge clk); #1;
        bus.mem_we = 1'b0; bus.mem_wa = 9'd0; bus.mem_wd = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        bus.mem_wa = 9'd511; bus.mem_wd = 32'h0;
        @(posedge clk); #1;
        chk("we0_mem0",   136'(bus.mem_rd1), 136'(32'hBEEF));
        chk("we0_mem511", 136'(bus.mem_rd0), 136'(32'hDEAD));

        // asynchronous reset mid-cycle, with writes attempted while held
        bus.mem_ra = 9'h20;
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("rst_async_rd", bus.cache_rd, '0);
        bus.cache_we = 1'b1; bus.cache_wa = 4'd5; bus.cache_wd = L5;
        bus.mem_we = 1'b1; bus.mem_wa = 9'h20; bus.mem_wd = 32'hBAD;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        bus.cache_we = 1'b0; bus.mem_we = 1'b0;
        rst = 1'b0; #1;
        chk("rst_mem_kept", 136'(bus.mem_rd0), 136'(32'hA0));
        chk("rst_mem_rd1",  136'(bus.mem_rd1), 136'(32'h5555));

        step(mk("rd5_after_rst", 1, 4'd5, 0, 4'd0, '0, '0));
        step(mk("rd9_after_rst", 1, 4'd9, 0, 4'd0, '0, '0));
        @(negedge clk); #1;
        chk("valid5_clear", 136'(bus.cache_rd[VALID_BIT]), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
